// File: rtl/regfile_pkg.sv
// Shared defaults and address types for the multi-ported register file and its scoreboard.
package regfile_pkg;

  localparam int DEF_XLEN = 64;
  localparam int DEF_NREG = 32;
  localparam int DEF_NR   = 2;
  localparam int DEF_NW   = 2;

  typedef logic [$clog2(DEF_NREG)-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: alloc sets, a retiring write clears, and alloc wins a same-cycle tie.
// REGFILE_BYPASS_EN lets a same-cycle clear drop rd_busy immediately.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int NR   = DEF_NR,
  localparam int AW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_en,
  input  logic [AW-1:0]    alloc_addr,
  input  logic [NREG-1:0]  clr,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR-1:0]    rd_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] alloc_hit;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    alloc_hit = '0;
    if (alloc_en && alloc_addr != AW'(0)) alloc_hit[alloc_addr] = 1'b1;
  end

  // The new producer supersedes the retiring one, so alloc is ORed in after the clear.
  always_comb begin
    busy_next    = (busy & ~clr) | alloc_hit;
    busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NR; i++) begin
      logic [AW-1:0] ra;
      ra = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      rd_busy[i] = busy[ra] & ~(clr[ra] & ~alloc_hit[ra]);
`else
      rd_busy[i] = busy[ra];
`endif
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// NR-read / NW-write register file with x0 hardwired to zero, busy scoreboard and difftest snapshot.
// REGFILE_BYPASS_EN forwards same-cycle writes and clears to the read ports.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NR   = DEF_NR,
  parameter int NW   = DEF_NW,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NR*AW-1:0]     rd_addr,
  output logic [NR*XLEN-1:0]   rd_data,
  output logic [NR-1:0]        rd_busy,
  input  logic [NW-1:0]        wr_en,
  input  logic [NW*AW-1:0]     wr_addr,
  input  logic [NW*XLEN-1:0]   wr_data,
  input  logic [NW-1:0]        wr_clr,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic [NREG*XLEN-1:0] regs_o
);

  logic [XLEN-1:0] mem      [NREG];
  logic [XLEN-1:0] win_data [NREG];
  logic [NREG-1:0] win_en;
  logic [NREG-1:0] win_clr;

  // Ascending port scan: the highest-indexed matching port overwrites earlier ones.
  always_comb begin
    win_en  = '0;
    win_clr = '0;
    for (int k = 0; k < NREG; k++) win_data[k] = '0;
    for (int k = 1; k < NREG; k++) begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(k)) begin
          win_en[k]   = 1'b1;
          win_data[k] = wr_data[j*XLEN +: XLEN];
          win_clr[k]  = wr_clr[j];
        end
      end
    end
  end

  // NOTE: the array is architectural state that difftest compares, so it is reset like any register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) mem[k] <= '0;
    end else begin
      for (int k = 1; k < NREG; k++)
        if (win_en[k]) mem[k] <= win_data[k];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NR; i++) begin
      logic [AW-1:0] ra;
      ra = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      rd_data[i*XLEN +: XLEN] = win_en[ra] ? win_data[ra] : mem[ra];
`else
      rd_data[i*XLEN +: XLEN] = mem[ra];
`endif
    end
  end

  // Snapshot reflects this cycle's winning writes regardless of the bypass build.
  always_comb begin
    regs_o = '0;
    for (int k = 1; k < NREG; k++)
      regs_o[k*XLEN +: XLEN] = win_en[k] ? win_data[k] : mem[k];
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NR   (NR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .clr        (win_en & win_clr),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: stimulus queues expected values, a negedge monitor compares them.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NR   = 2;
  localparam int NW   = 2;
  localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NR*AW-1:0]     rd_addr;
  logic [NR*XLEN-1:0]   rd_data;
  logic [NR-1:0]        rd_busy;
  logic [NW-1:0]        wr_en;
  logic [NW*AW-1:0]     wr_addr;
  logic [NW*XLEN-1:0]   wr_data;
  logic [NW-1:0]        wr_clr;
  logic                 alloc_en;
  logic [AW-1:0]        alloc_addr;
  logic [NREG*XLEN-1:0] regs_o;

  regfile_mp_sb #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NR   (NR),
    .NW   (NW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_clr     (wr_clr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .regs_o     (regs_o)
  );

  always #5 clk = ~clk;

  typedef enum int {K_DATA, K_BUSY, K_REGS} kind_e;

  typedef struct {
    string       name;
    int          cyc;
    kind_e       kind;
    int          idx;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: at the falling edge compare every expectation queued for the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        exp_t e;
        logic [63:0] act;
        e = q.pop_front();
        case (e.kind)
          K_DATA:  act = rd_data[e.idx*XLEN +: XLEN];
          K_BUSY:  act = {63'b0, rd_busy[e.idx]};
          default: act = regs_o[e.idx*XLEN +: XLEN];
        endcase
        if (e.cyc < cyc) check({e.name, "_missed"}, 64'hx, e.val);
        else             check(e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input string name, input kind_e kind, input int idx, input logic [63:0] v);
    q.push_back('{name: name, cyc: cyc, kind: kind, idx: idx, val: v});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    wr_en      = '0;
    wr_clr     = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int j, input int a, input logic [63:0] d, input bit c);
    wr_en[j]                = 1'b1;
    wr_addr[j*AW +: AW]     = AW'(a);
    wr_data[j*XLEN +: XLEN] = d;
    wr_clr[j]               = c;
  endtask

  task automatic alloc(input int a);
    alloc_en   = 1'b1;
    alloc_addr = AW'(a);
  endtask

  initial begin
    rst_n      = 1'b0;
    rd_addr    = '0;
    wr_en      = '0;
    wr_clr     = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    repeat (2) next_cycle();

    // Out of reset: everything reads zero
    rst_n = 1'b1;
    set_rd(0, 5); set_rd(1, 31);
    expect_v("rst_data0", K_DATA, 0, 64'h0);
    expect_v("rst_data1", K_DATA, 1, 64'h0);
    expect_v("rst_busy0", K_BUSY, 0, 64'h0);
    expect_v("rst_busy1", K_BUSY, 1, 64'h0);
    expect_v("rst_regs31", K_REGS, 31, 64'h0);

    // x0 ignores writes and allocs
    next_cycle();
    wr(0, int'(ZERO_REG), 64'hDEAD, 1'b0);
    alloc(0);
    set_rd(0, 0);
    expect_v("x0_same_data", K_DATA, 0, 64'h0);
    expect_v("x0_same_regs", K_REGS, 0, 64'h0);
    next_cycle();
    expect_v("x0_next_data", K_DATA, 0, 64'h0);
    expect_v("x0_next_busy", K_BUSY, 0, 64'h0);
    expect_v("x0_next_regs", K_REGS, 0, 64'h0);

    // Same-address collision: port 1 wins
    next_cycle();
    wr(0, 7, 64'h11, 1'b0);
    wr(1, 7, 64'h22, 1'b0);
    set_rd(0, 7);
    expect_v("x7_same_data", K_DATA, 0, BYP ? 64'h22 : 64'h0);
    expect_v("x7_same_regs", K_REGS, 7, 64'h22);
    next_cycle();
    expect_v("x7_next_data", K_DATA, 0, 64'h22);

    // Write-to-read latency on x3
    next_cycle();
    wr(0, 3, 64'h1234, 1'b0);
    set_rd(1, 3);
    expect_v("x3_same_data", K_DATA, 1, BYP ? 64'h1234 : 64'h0);
    expect_v("x3_same_regs", K_REGS, 3, 64'h1234);
    next_cycle();
    expect_v("x3_next_data", K_DATA, 1, 64'h1234);

    // Alloc x9 at N; clear plus re-alloc at N+3 keeps it busy
    next_cycle();
    alloc(9);
    set_rd(0, 9);
    expect_v("x9_alloc_n", K_BUSY, 0, 64'h0);
    next_cycle();
    expect_v("x9_busy_n1", K_BUSY, 0, 64'h1);
    next_cycle();
    expect_v("x9_busy_n2", K_BUSY, 0, 64'h1);
    next_cycle();
    wr(1, 9, 64'h99, 1'b1);
    alloc(9);
    expect_v("x9_clr_alloc_n3", K_BUSY, 0, 64'h1);
    next_cycle();
    expect_v("x9_busy_n4", K_BUSY, 0, 64'h1);
    expect_v("x9_data_n4", K_DATA, 0, 64'h99);

    // x4: losing port's clear is ignored, then a real clear
    next_cycle();
    alloc(4);
    set_rd(1, 4);
    next_cycle();
    wr(0, 4, 64'h40, 1'b1);
    wr(1, 4, 64'h41, 1'b0);
    expect_v("x4_busy_a1", K_BUSY, 1, 64'h1);
    next_cycle();
    wr(0, 4, 64'h44, 1'b1);
    expect_v("x4_clr_m_busy", K_BUSY, 1, BYP ? 64'h0 : 64'h1);
    expect_v("x4_clr_m_data", K_DATA, 1, BYP ? 64'h44 : 64'h41);
    next_cycle();
    expect_v("x4_clr_m1_busy", K_BUSY, 1, 64'h0);
    expect_v("x4_clr_m1_data", K_DATA, 1, 64'h44);

    // Re-alloc x4, then reset mid-operation with an alloc and write in flight
    next_cycle();
    alloc(4);
    next_cycle();
    expect_v("x4_realloc_busy", K_BUSY, 1, 64'h1);
    next_cycle();
    rst_n = 1'b0;
    alloc(4);
    wr(0, 4, 64'h55, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    set_rd(0, 7);
    expect_v("post_rst_busy4", K_BUSY, 1, 64'h0);
    expect_v("post_rst_data4", K_DATA, 1, 64'h0);
    expect_v("post_rst_data7", K_DATA, 0, 64'h0);
    expect_v("post_rst_regs3", K_REGS, 3, 64'h0);

    // Drain the expectation queue within a bounded number of cycles
    for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
    check("queue_drain", 64'(q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
